// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver (8N1 / 8-parity-1)
// with a small error-tagged receive FIFO and valid/ready drain.
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BIT_RATE    = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          RX,
    output logic [7:0]                    data_out,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clr,
    output logic                          UART_Busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV_RAW = CLK_FREQ_HZ / (BIT_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [SW-1:0] MID_START = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] MID_BIT   = SW'(OVERSAMPLE - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic          PAR_ON    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic [1:0]    sync_q;
    logic          rx_s;

    state_e        state_q, state_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          perr_q, perr_d;
    logic          busy_q;
    logic          push;
    logic          push_ferr;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          valid_q;
    logic          ovr_q, ovr_d;
    logic          rd, wr, full, ovr_set;
    logic [9:0]    head;

    assign tick = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + 1'b1;
    assign rx_s = sync_q[1];

    // Free-running baud tick divider, never resynchronised to the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], RX};
    end

    // Frame state machine: next state, sample counter, shifter, push.
    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        perr_d    = perr_q;
        push      = 1'b0;
        push_ferr = 1'b0;
        if (tick) begin
            sc_d = sc_q + 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    sc_d = '0;
                    if (!rx_s) state_d = S_START;
                end
                S_START: begin
                    if (sc_q == MID_START) begin
                        if (rx_s) begin
                            state_d = S_IDLE;
                        end else begin
                            sc_d    = '0;
                            idx_d   = '0;
                            perr_d  = 1'b0;
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (sc_q == MID_BIT) begin
                        sh_d  = {rx_s, sh_q[7:1]};
                        sc_d  = '0;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == 3'd7)
                            state_d = PAR_ON ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (sc_q == MID_BIT) begin
                        perr_d  = ((^sh_q) ^ rx_s) != PAR_ODD;
                        sc_d    = '0;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (sc_q == MID_BIT) begin
                        push      = 1'b1;
                        push_ferr = !rx_s;
                        sc_d      = '0;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Frame state registers; busy is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sc_q    <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign rd      = valid_q & rx_ready;
    assign full    = (cnt_q == FULL_CNT);
    assign wr      = push & (~full | rd);
    assign ovr_set = push & full & ~rd;

    // Occupancy and sticky overrun next-state; a new overrun beats clear.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr, rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        ovr_d = ovr_q;
        if (ovr_set)      ovr_d = 1'b1;
        else if (err_clr) ovr_d = 1'b0;
    end

    // FIFO pointers, count, valid flag and overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (wr) wp_q <= wp_q + 1'b1;
            if (rd) rp_q <= rp_q + 1'b1;
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
            ovr_q   <= ovr_d;
        end
    end

    // Entry storage {frame_err, parity_err, data}; cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (wr) begin
            mem_q[wp_q] <= {push_ferr, perr_q, sh_q};
        end
    end

    assign head       = mem_q[rp_q];
    assign data_out   = head[7:0];
    assign parity_err = head[8];
    assign frame_err  = head[9];
    assign rx_valid   = valid_q;
    assign overrun    = ovr_q;
    assign UART_Busy  = busy_q;
    assign fifo_count = cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: random and directed frames against a queue-based
// reference of the receive FIFO; one 8N1 and one even-parity instance.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 614_400;
    localparam int BR     = 9600;
    localparam int OS     = 16;
    localparam int DEPTH  = 4;
    localparam int DIVV   = 4;
    localparam int BITC   = OS * DIVV;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       rx0, rdy0, clr0, v0, fe0, pe0, ov0, busy0;
    logic [7:0] d0;
    logic [2:0] cnt0;
    logic       rx1, rdy1, clr1, v1, fe1, pe1, ov1, busy1;
    logic [7:0] d1;
    logic [2:0] cnt1;

    uart_rx_fifo #(
        .CLK_FREQ_HZ(CLK_HZ), .BIT_RATE(BR), .OVERSAMPLE(OS),
        .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)
    ) u0 (
        .clk(clk), .rst(rst), .RX(rx0), .data_out(d0), .rx_valid(v0),
        .rx_ready(rdy0), .frame_err(fe0), .parity_err(pe0),
        .overrun(ov0), .err_clr(clr0), .UART_Busy(busy0),
        .fifo_count(cnt0)
    );

    uart_rx_fifo #(
        .CLK_FREQ_HZ(CLK_HZ), .BIT_RATE(BR), .OVERSAMPLE(OS),
        .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)
    ) u1 (
        .clk(clk), .rst(rst), .RX(rx1), .data_out(d1), .rx_valid(v1),
        .rx_ready(rdy1), .frame_err(fe1), .parity_err(pe1),
        .overrun(ov1), .err_clr(clr1), .UART_Busy(busy1),
        .fifo_count(cnt1)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc;
    int mcnt;
    bit movr;
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst && v0 && rdy0) got_q.push_back({fe0, pe0, d0});
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference FIFO: an entry is kept unless the FIFO is full with no
    // read in that cycle; "consumed" means a read accompanies the push.
    function automatic void model_push(input logic [9:0] e, input bit consumed);
        if (consumed) begin
            exp_q.push_back(e);
        end else if (mcnt == DEPTH) begin
            movr = 1'b1;
        end else begin
            exp_q.push_back(e);
            mcnt++;
        end
    endfunction

    // mode 0: leave ready; 1: ready only on the push cycle; 2: random ready
    task automatic send0(input logic [7:0] d, input bit stopv, input int mode);
        logic [9:0] bits;
        int p, rs, n, pc;
        bits = {stopv, d, 1'b0};
        p  = cyc;
        rs = p + 2;
        n  = rs + ((DIVV - 1 - (rs % DIVV)) + DIVV) % DIVV;
        pc = n + (OS / 2) * DIVV + 9 * BITC;
        for (int j = 0; j < 10; j++) begin
            rx0 = bits[j];
            for (int k = 0; k < BITC; k++) begin
                if (mode == 1)      rdy0 = (cyc == pc);
                else if (mode == 2) rdy0 = 1'($urandom_range(0, 1));
                step(1);
            end
        end
        rx0 = 1'b1;
        if (mode != 0) rdy0 = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d, input bit pbit);
        logic [10:0] bits;
        bits = {1'b1, pbit, d, 1'b0};
        for (int j = 0; j < 11; j++) begin
            rx1 = bits[j];
            step(BITC);
        end
        rx1 = 1'b1;
    endtask

    task automatic drain0();
        rdy0 = 1'b1;
        step(DEPTH + 2);
        rdy0 = 1'b0;
        mcnt = 0;
    endtask

    task automatic cmp_q();
        int m;
        check("rx_count", got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check("rx_entry", got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic par_case(input logic [7:0] d, input bit pbit);
        send1(d, pbit);
        step(4);
        check("par_valid", v1, 1'b1);
        check("par_data", d1, d);
        check("par_perr", pe1, 1'(($countones(d) + pbit) % 2));
        check("par_ferr", fe1, 1'b0);
        rdy1 = 1'b1;
        step(1);
        rdy1 = 1'b0;
        check("par_pop", v1, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b, b5;
        logic [9:0] lastv;
        bit sv;
        int p;
        rst = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1;
        rdy0 = 1'b0; rdy1 = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0;
        mcnt = 0; movr = 1'b0;
        step(3);
        check("rst_valid", v0, 1'b0);
        check("rst_data", d0, 8'h00);
        check("rst_ferr", fe0, 1'b0);
        check("rst_perr", pe0, 1'b0);
        check("rst_ovr", ov0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_cnt", cnt0, 3'd0);
        check("rst_cnt1", cnt1, 3'd0);
        rst = 1'b0;
        step(2);

        send0(8'hA5, 1'b1, 0);
        model_push({2'b00, 8'hA5}, 1'b0);
        step(4);
        check("basic_valid", v0, 1'b1);
        check("basic_data", d0, 8'hA5);
        check("basic_ferr", fe0, 1'b0);
        check("basic_perr", pe0, 1'b0);
        check("basic_cnt", cnt0, mcnt);
        rdy0 = 1'b1;
        step(1);
        rdy0 = 1'b0;
        mcnt = 0;
        check("basic_pop_valid", v0, 1'b0);
        check("basic_pop_cnt", cnt0, 3'd0);
        cmp_q();

        par_case(8'h03, 1'b0);
        par_case(8'h03, 1'b1);
        for (int i = 0; i < 4; i++) par_case(8'($urandom), 1'($urandom));
        check("par_ovr", ov1, 1'b0);

        send0(8'h55, 1'b0, 0);
        model_push({2'b10, 8'h55}, 1'b0);
        step(60);
        check("frame_ferr", fe0, 1'b1);
        check("frame_data", d0, 8'h55);
        check("frame_cnt", cnt0, mcnt);
        drain0();
        cmp_q();

        p = cyc;
        rx0 = 1'b0;
        step(10);
        check("glitch_busy_on", busy0, 1'b1);
        step(10);
        rx0 = 1'b1;
        step(40 - (cyc - p));
        check("glitch_busy_off", busy0, 1'b0);
        check("glitch_cnt", cnt0, 3'd0);
        check("glitch_valid", v0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            b = 8'h10 + 8'(i);
            send0(b, 1'b1, 0);
            model_push({2'b00, b}, 1'b0);
        end
        step(4);
        check("ovr_cnt", cnt0, mcnt);
        check("ovr_flag", ov0, movr);
        drain0();
        cmp_q();
        check("ovr_sticky", ov0, 1'b1);
        clr0 = 1'b1;
        step(1);
        clr0 = 1'b0;
        movr = 1'b0;
        check("ovr_clr", ov0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send0(b, 1'b1, 0);
            model_push({2'b00, b}, 1'b0);
        end
        b5 = 8'($urandom);
        send0(b5, 1'b1, 1);
        model_push({2'b00, b5}, 1'b1);
        step(4);
        check("simrd_ovr", ov0, movr);
        check("simrd_cnt", cnt0, mcnt);
        drain0();
        lastv = (got_q.size() > 0) ? got_q[got_q.size() - 1] : 10'bx;
        check("simrd_last", lastv, {2'b00, b5});
        cmp_q();

        send0(8'h77, 1'b1, 0);
        rx0 = 1'b0; step(BITC);
        rx0 = 1'b1; step(BITC);
        rx0 = 1'b0; step(BITC);
        rst = 1'b1;
        rx0 = 1'b1;
        step(1);
        check("mrst_valid", v0, 1'b0);
        check("mrst_cnt", cnt0, 3'd0);
        check("mrst_busy", busy0, 1'b0);
        check("mrst_data", d0, 8'h00);
        check("mrst_ferr", fe0, 1'b0);
        check("mrst_ovr", ov0, 1'b0);
        step(2);
        rst = 1'b0;
        mcnt = 0;
        step(2);
        send0(8'h3C, 1'b1, 0);
        model_push({2'b00, 8'h3C}, 1'b0);
        step(4);
        check("mrst_rx_cnt", cnt0, mcnt);
        drain0();
        cmp_q();

        for (int i = 0; i < 8; i++) begin
            b  = 8'($urandom);
            sv = ($urandom % 4) != 0;
            send0(b, sv, 2);
            model_push({~sv, 1'b0, b}, 1'b1);
            step(sv ? int'($urandom_range(1, 20)) : 60);
        end
        drain0();
        cmp_q();
        check("rand_ovr", ov0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
